// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The master side is the controller: it consumes the instruction register,
// memory acknowledge and ALU zero flag, and drives every control strobe.
interface multicycle_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] instr_in;
  logic             mem_ready;
  logic             zero_in;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic [1:0]       alu_src_b;
  logic             alu_src_a;
  logic [1:0]       alu_op;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic [2:0]       state_o;
  logic             illegal_o;

  modport master (
    input  instr_in, mem_ready, zero_in,
    output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
           alu_src_b, alu_src_a, alu_op, reg_we, wb_sel, state_o, illegal_o
  );

  modport slave (
    output instr_in, mem_ready, zero_in,
    input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
           alu_src_b, alu_src_a, alu_op, reg_we, wb_sel, state_o, illegal_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Decoding reads the external instruction register (instr_in), which is only
// valid after the FETCH acknowledge has loaded it, so FETCH never looks at it.
module multicycle_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;

  logic [WIDTH-1:0] w_instr;
  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic             w_unused;

  logic             w_is_load;
  logic             w_is_store;
  logic             w_is_imm;
  logic             w_is_rtype;
  logic             w_is_branch;
  logic             w_is_jal;
  logic             w_legal;

  logic             w_mem_req;
  logic             w_mem_we;
  logic             w_addr_sel;
  logic             w_ir_we;
  logic             w_pc_we;
  logic [1:0]       w_pc_src;
  logic [1:0]       w_alu_src_b;
  logic             w_alu_src_a;
  logic [1:0]       w_alu_op;
  logic             w_reg_we;
  logic [1:0]       w_wb_sel;
  logic             w_taken;

  assign w_instr  = bus.instr_in;
  assign w_opcode = w_instr[6:0];
  assign w_funct3 = w_instr[14:12];
  assign w_unused = &{1'b0, w_instr[WIDTH-1:15], w_instr[11:7]};

  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_imm    = (w_opcode == OP_IMM);
  assign w_is_rtype  = (w_opcode == OP_RTYPE);
  assign w_is_branch = (w_opcode == OP_BRANCH);
  assign w_is_jal    = (w_opcode == OP_JAL);
  assign w_legal     = w_is_load | w_is_store | w_is_imm | w_is_rtype |
                       w_is_branch | w_is_jal;

  // State register and sticky illegal flag; reset returns to FETCH at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == TRAP) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Next-state and control strobes; Mealy terms only on handshake/branch outcome.
  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_addr_sel  = 1'b0;
    w_ir_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_src    = 2'd0;
    w_alu_src_b = 2'd0;
    w_alu_src_a = 1'b0;
    w_alu_op    = 2'd0;
    w_reg_we    = 1'b0;
    w_wb_sel    = 2'd0;
    w_taken     = 1'b0;

    unique case (r_state)
      FETCH: begin
        // Request is held off while reset is asserted, so a stray
        // mem_ready during reset can never complete a fetch.
        w_mem_req = rst_n;
        if (rst_n && bus.mem_ready) begin
          w_ir_we  = 1'b1;
          w_pc_we  = 1'b1;
          w_pc_src = 2'd0;
          w_next   = DECODE;
        end
      end

      DECODE: begin
        w_alu_src_a = 1'b0;
        w_alu_src_b = 2'd2;
        w_alu_op    = 2'd0;
        w_next      = w_legal ? EXEC : TRAP;
      end

      EXEC: begin
        if (w_is_load || w_is_store) begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'd2;
          w_alu_op    = 2'd0;
          w_next      = MEM;
        end else if (w_is_imm) begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'd2;
          w_alu_op    = 2'd2;
          w_next      = WB;
        end else if (w_is_rtype) begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'd0;
          w_alu_op    = 2'd2;
          w_next      = WB;
        end else if (w_is_branch) begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'd0;
          w_alu_op    = 2'd1;
          if (w_funct3 == 3'b000) begin
            w_taken = bus.zero_in;
            w_next  = FETCH;
          end else if (w_funct3 == 3'b001) begin
            w_taken = ~bus.zero_in;
            w_next  = FETCH;
          end else begin
            w_next  = TRAP;
          end
          if (w_taken) begin
            w_pc_we  = 1'b1;
            w_pc_src = 2'd1;
          end
        end else if (w_is_jal) begin
          w_pc_we  = 1'b1;
          w_pc_src = 2'd1;
          w_reg_we = 1'b1;
          w_wb_sel = 2'd2;
          w_next   = FETCH;
        end else begin
          w_next = TRAP;
        end
      end

      MEM: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = w_is_store;
        if (bus.mem_ready) begin
          w_next = w_is_store ? FETCH : WB;
        end
      end

      WB: begin
        w_reg_we = 1'b1;
        w_wb_sel = w_is_load ? 2'd1 : 2'd0;
        w_next   = FETCH;
      end

      TRAP: begin
        w_next = TRAP;
      end

      default: begin
        w_next = FETCH;
      end
    endcase
  end

  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.addr_sel  = w_addr_sel;
  assign bus.ir_we     = w_ir_we;
  assign bus.pc_we     = w_pc_we;
  assign bus.pc_src    = w_pc_src;
  assign bus.alu_src_b = w_alu_src_b;
  assign bus.alu_src_a = w_alu_src_a;
  assign bus.alu_op    = w_alu_op;
  assign bus.reg_we    = w_reg_we;
  assign bus.wb_sel    = w_wb_sel;
  assign bus.state_o   = r_state;
  assign bus.illegal_o = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a reference model expands each instruction into
// its expected per-cycle control trace (from the instruction class, memory
// wait counts and zero flag), which is then replayed against the controller.
module tb_multicycle_ctrl;

  localparam logic [2:0] S_F = 3'd0;
  localparam logic [2:0] S_D = 3'd1;
  localparam logic [2:0] S_E = 3'd2;
  localparam logic [2:0] S_M = 3'd3;
  localparam logic [2:0] S_W = 3'd4;
  localparam logic [2:0] S_T = 3'd5;

  typedef struct {
    logic [2:0]  st;
    int          rdy;   // 0/1 forced mem_ready, 2 = random (must be ignored)
    bit          z;
    logic [31:0] ins;
    logic [18:0] exp;
  } ent_t;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nmis;
  ent_t q[$];

  multicycle_ctrl_if #(.WIDTH(32)) bus ();

  multicycle_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] vec(
    input logic [2:0] st, input bit req, input bit we, input bit asel,
    input bit irwe, input bit pcwe, input logic [1:0] pcs, input bit asrc,
    input logic [1:0] bsrc, input logic [1:0] aop, input bit rwe,
    input logic [1:0] wbs, input bit ill);
    return {st, req, we, asel, irwe, pcwe, pcs, asrc, bsrc, aop, rwe, wbs, ill};
  endfunction

  function automatic logic [18:0] sample();
    return {bus.state_o, bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we,
            bus.pc_we, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.reg_we, bus.wb_sel, bus.illegal_o};
  endfunction

  function automatic void push(input logic [2:0] st, input int rdy, input bit z,
                               input logic [31:0] ins, input logic [18:0] e);
    ent_t n;
    n.st = st; n.rdy = rdy; n.z = z; n.ins = ins; n.exp = e;
    q.push_back(n);
  endfunction

  // Expected trace of one instruction; returns 1 if it ends in TRAP.
  function automatic bit build(input logic [31:0] ins, input bit z,
                               input int unsigned wf, input int unsigned wm,
                               input bit cut);
    logic [6:0]  opc = ins[6:0];
    logic [2:0]  f3  = ins[14:12];
    logic [18:0] mv;
    bit          st;
    bit          tk;
    for (int unsigned i = 0; i < wf; i++)
      push(S_F, 0, z, ins, vec(S_F, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0));
    push(S_F, 1, z, ins, vec(S_F, 1, 0, 0, 1, 1, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0));
    push(S_D, 2, z, ins, vec(S_D, 0, 0, 0, 0, 0, 2'd0, 0, 2'd2, 2'd0, 0, 2'd0, 0));
    case (opc)
      7'b0000011, 7'b0100011: begin
        st = (opc == 7'b0100011);
        push(S_E, 2, z, ins, vec(S_E, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'd0, 0, 2'd0, 0));
        mv = vec(S_M, 1, st, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0);
        for (int unsigned i = 0; i < wm; i++) push(S_M, 0, z, ins, mv);
        if (cut) return 1'b0;
        push(S_M, 1, z, ins, mv);
        if (!st)
          push(S_W, 2, z, ins, vec(S_W, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd1, 0));
        return 1'b0;
      end
      7'b0010011, 7'b0110011: begin
        push(S_E, 2, z, ins, vec(S_E, 0, 0, 0, 0, 0, 2'd0, 1,
                                 (opc == 7'b0010011) ? 2'd2 : 2'd0, 2'd2, 0, 2'd0, 0));
        push(S_W, 2, z, ins, vec(S_W, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd0, 0));
        return 1'b0;
      end
      7'b1100011: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          tk = (f3 == 3'b000) ? z : !z;
          push(S_E, 2, z, ins, vec(S_E, 0, 0, 0, 0, tk, tk ? 2'd1 : 2'd0, 1, 2'd0, 2'd1,
                                   0, 2'd0, 0));
          return 1'b0;
        end
        push(S_E, 2, z, ins, vec(S_E, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 0, 2'd0, 0));
      end
      7'b1101111: begin
        push(S_E, 2, z, ins, vec(S_E, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 1, 2'd2, 0));
        return 1'b0;
      end
      default: ;
    endcase
    for (int i = 0; i < 2; i++)
      push(S_T, 2, z, ins, vec(S_T, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 1));
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [18:0] exp);
    logic [18:0] obs;
    obs = sample();
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_trace(input string tag);
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      bus.mem_ready = (e.rdy == 2) ? 1'($urandom_range(0, 1)) : (e.rdy == 1);
      bus.zero_in   = e.z;
      bus.instr_in  = (e.st == S_F) ? 32'($urandom) : e.ins;
      #1;
      chk($sformatf("%s instr=%h st=%0d", tag, e.ins, e.st), e.exp);
    end
  endtask

  // Asserts reset mid-cycle (away from any edge), checks the immediate
  // effect, holds it across one edge, then releases just after that edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1 chk({tag, " in-reset"}, '0);
    @(posedge clk);
    #1 chk({tag, " held"}, '0);
    rst_n = 1'b1;
  endtask

  logic [31:0] ins;
  bit          trapped;

  initial begin
    nvec = 0;
    nmis = 0;
    rst_n = 1'b0;
    bus.instr_in  = '0;
    bus.mem_ready = 1'b1;
    bus.zero_in   = 1'b0;
    #1 chk("reset", '0);
    @(posedge clk);
    #1 chk("reset held", '0);
    rst_n = 1'b1;

    void'(build(32'h00500093, 1'b0, 0, 0, 1'b0));
    run_trace("addi");
    void'(build(32'h00002083, 1'b1, 1, 3, 1'b0));
    run_trace("lw");
    void'(build(32'h00000063, 1'b1, 0, 0, 1'b0));
    run_trace("beq z1");
    void'(build(32'h00000063, 1'b0, 0, 0, 1'b0));
    run_trace("beq z0");
    void'(build(32'h00001063, 1'b0, 0, 0, 1'b0));
    run_trace("bne z0");
    void'(build(32'h00001063, 1'b1, 2, 0, 1'b0));
    run_trace("bne z1");
    void'(build(32'h008000EF, 1'b0, 0, 0, 1'b0));
    run_trace("jal");
    void'(build(32'h002081B3, 1'b0, 0, 0, 1'b0));
    run_trace("add");
    void'(build(32'h00102023, 1'b0, 0, 1, 1'b0));
    run_trace("sw");
    void'(build(32'h00102023, 1'b0, 0, 2, 1'b1));
    run_trace("sw cut");
    async_reset("sw mem reset");
    void'(build(32'h0000007F, 1'b0, 0, 0, 1'b0));
    run_trace("op7f");
    async_reset("trap reset");
    void'(build(32'h00002063, 1'b1, 0, 0, 1'b0));
    run_trace("branch f3=2");
    async_reset("branch trap reset");

    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 7))
        0: ins[6:0] = 7'b0000011;
        1: ins[6:0] = 7'b0100011;
        2: ins[6:0] = 7'b0010011;
        3: ins[6:0] = 7'b0110011;
        4: begin
          ins[6:0]   = 7'b1100011;
          ins[14:12] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 7))
                                                   : 3'($urandom_range(0, 1));
        end
        5: ins[6:0] = 7'b1101111;
        6: ins[6:0] = 7'b1101111;
        default: begin
          if (ins[6:0] inside {7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
                               7'b1100011, 7'b1101111})
            ins[6:0] = 7'h7F;
        end
      endcase
      trapped = build(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'b0);
      run_trace("rand");
      if (trapped) async_reset("rand trap reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
